sha256_padder: RTL

- Upstream feeder for the SHA-256 compression core.
- Accepts a message as a byte stream with a valid/ready handshake and packs it into big-endian 512-bit blocks.
- Applies FIPS 180-4 padding: 0x80, then zeros, then the 64-bit bit-length.
- Sequences the core one block at a time, chains intermediate hashes through the core's hash_init/use_init inputs, and presents the final 256-bit digest.

---
 rtl/sha256_padder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder and block sequencer
// Packs a byte stream into 512-bit blocks, applies padding and chains the core.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [511:0] core_block,
  output logic         core_start,
  output logic         core_use_init,
  output logic [255:0] core_hash_init,
  input  logic [255:0] core_hash,
  input  logic         core_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_SEND, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [511:0]       buf_q, buf_d;
  logic [6:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               marker_q, marker_d;
  logic               msg_end_q, msg_end_d;
  logic               last_blk_q, last_blk_d;
  logic [255:0]       chain_q, chain_d;
  logic [255:0]       digest_q, digest_d;
  logic               digest_valid_q, digest_valid_d;

  logic [511:0]       fill_blk;
  logic [511:0]       pad_blk;
  logic [6:0]         pad_pos;
  logic               pad_mark;
  logic               pad_fits;

  always_comb begin
    fill_blk = buf_q;
    for (int l = 0; l < 64; l++) begin
      if (idx_q == 7'(l)) fill_blk[511-8*l -: 8] = in_data;
    end
  end

  // pad_pos is the first lane after data and marker; the length only fits if it is <= 56
  always_comb begin
    pad_mark = 1'b0;
    pad_pos  = idx_q;
    if (!marker_q && (idx_q < 7'd64)) begin
      pad_mark = 1'b1;
      pad_pos  = idx_q + 7'd1;
    end
    pad_fits = (pad_pos <= 7'd56);
    pad_blk  = buf_q;
    for (int l = 0; l < 64; l++) begin
      if (pad_mark && (idx_q == 7'(l))) begin
        pad_blk[511-8*l -: 8] = 8'h80;
      end else if (7'(l) >= pad_pos) begin
        pad_blk[511-8*l -: 8] = 8'h00;
      end
    end
    if (pad_fits) pad_blk[63:0] = 64'(len_q);
  end

  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    idx_d          = idx_q;
    len_d          = len_q;
    blk_cnt_d      = blk_cnt_q;
    marker_d       = marker_q;
    msg_end_d      = msg_end_q;
    last_blk_d     = last_blk_q;
    chain_d        = chain_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    in_ready       = 1'b0;
    core_start     = 1'b0;

    case (state_q)
      S_IDLE, S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d = fill_blk;
          idx_d = idx_q + 7'd1;
          len_d = len_q + LEN_W'(8);
          if (in_last) begin
            msg_end_d = 1'b1;
            state_d   = S_PAD;
          end else if (idx_q == 7'd63) begin
            last_blk_d = 1'b0;
            state_d    = S_SEND;
          end else begin
            state_d = S_FILL;
          end
        end else if ((state_q == S_IDLE) && in_empty) begin
          idx_d     = 7'd0;
          len_d     = '0;
          msg_end_d = 1'b1;
          state_d   = S_PAD;
        end
      end
      S_PAD: begin
        buf_d      = pad_blk;
        idx_d      = pad_pos;
        last_blk_d = pad_fits;
        if (pad_mark) marker_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_ready) begin
          chain_d   = core_hash;
          blk_cnt_d = blk_cnt_q + LEN_W'(1);
          buf_d     = '0;
          idx_d     = 7'd0;
          if (last_blk_q)     state_d = S_DONE;
          else if (msg_end_q) state_d = S_PAD;
          else                state_d = S_FILL;
        end
      end
      S_DONE: begin
        digest_d       = chain_q;
        digest_valid_d = 1'b1;
        len_d          = '0;
        blk_cnt_d      = '0;
        marker_d       = 1'b0;
        msg_end_d      = 1'b0;
        last_blk_d     = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      buf_q          <= '0;
      idx_q          <= '0;
      len_q          <= '0;
      blk_cnt_q      <= '0;
      marker_q       <= 1'b0;
      msg_end_q      <= 1'b0;
      last_blk_q     <= 1'b0;
      chain_q        <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      blk_cnt_q      <= blk_cnt_d;
      marker_q       <= marker_d;
      msg_end_q      <= msg_end_d;
      last_blk_q     <= last_blk_d;
      chain_q        <= chain_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign core_block     = buf_q;
  assign core_use_init  = (blk_cnt_q != '0);
  assign core_hash_init = chain_q;
  assign digest         = digest_q;
  assign digest_valid   = digest_valid_q;
  assign busy           = (state_q != S_IDLE);

endmodule
